// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC frame sequencer: FSM states,
// channel indices and default code limits.
package dac_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int FY1 = 0;
  localparam int FW1 = 1;
  localparam int FY2 = 2;
  localparam int FW2 = 3;
  localparam int NCH = 4;

  localparam logic [15:0] DEF_RESET_CODE = 16'h8000;
  localparam logic [15:0] DEF_CODE_MIN   = 16'h0000;
  localparam logic [15:0] DEF_CODE_MAX   = 16'hFFFF;
  localparam logic [15:0] DEF_MAX_STEP   = 16'd256;

endpackage

// File: rtl/dac_slew_step.sv
// One channel of combinational code conditioning: entry clamp of a raw code and
// the next issued code. Slew limiting is compiled in with DAC_SLEW_LIMIT_EN.
module dac_slew_step
  import dac_seq_pkg::*;
#(
  parameter logic [15:0] CODE_MIN = DEF_CODE_MIN,
  parameter logic [15:0] CODE_MAX = DEF_CODE_MAX,
  parameter logic [15:0] MAX_STEP = DEF_MAX_STEP
) (
  input  logic [15:0] i_raw,
  input  logic [15:0] i_target,
  input  logic [15:0] i_last,
  output logic [15:0] o_clamped,
  output logic [15:0] o_next
);

  function automatic logic [15:0] clamp_code(input logic [15:0] c);
    if (c < CODE_MIN) return CODE_MIN;
    if (c > CODE_MAX) return CODE_MAX;
    return c;
  endfunction

  assign o_clamped = clamp_code(i_raw);

`ifdef DAC_SLEW_LIMIT_EN
  // 17-bit signed so a full-scale difference never wraps.
  function automatic logic [15:0] slew_step(input logic [15:0] tgt, input logic [15:0] last);
    logic signed [16:0] lim;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] sum;
    lim  = $signed({1'b0, MAX_STEP});
    diff = $signed({1'b0, tgt}) - $signed({1'b0, last});
    if (diff > lim)       step = lim;
    else if (diff < -lim) step = -lim;
    else                  step = diff;
    sum = $signed({1'b0, last}) + step;
    return sum[15:0];
  endfunction

  assign o_next = slew_step(i_target, i_last);
`else
  logic w_unused_slew;
  assign w_unused_slew = ^{MAX_STEP, i_last};
  assign o_next        = i_target;
`endif

endmodule

// File: rtl/dac_frame_sequencer.sv
// Frame shadow buffer, update-tick generator and IDLE/ISSUE handshake FSM feeding
// a four-channel DAC driver group. Optional slew limiting: DAC_SLEW_LIMIT_EN.
module dac_frame_sequencer
  import dac_seq_pkg::*;
#(
  parameter int          UPDATE_DIV = 1000,
  parameter logic [15:0] CODE_MIN   = DEF_CODE_MIN,
  parameter logic [15:0] CODE_MAX   = DEF_CODE_MAX,
  parameter logic [15:0] RESET_CODE = DEF_RESET_CODE,
  parameter logic [15:0] MAX_STEP   = DEF_MAX_STEP
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [15:0] frame_fy1,
  input  logic [15:0] frame_fw1,
  input  logic [15:0] frame_fy2,
  input  logic [15:0] frame_fw2,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [15:0] dac_data_fy1,
  output logic [15:0] dac_data_fw1,
  output logic [15:0] dac_data_fy2,
  output logic [15:0] dac_data_fw2,
  output logic        dac_valid,
  input  logic        dac_ready,
  output logic        busy,
  output logic [7:0]  late_cnt
);

  localparam int               CNT_W    = $clog2(UPDATE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_shadow_full;
  logic [7:0]       r_late;
  logic [15:0]      r_shadow [NCH];
  logic [15:0]      r_target [NCH];
  logic [15:0]      r_last   [NCH];
  logic [15:0]      r_dac    [NCH];

  logic             w_tick;
  logic             w_accept;
  logic             w_work_pending;
  logic             w_issue;
  logic             w_done;
  logic [15:0]      w_frame   [NCH];
  logic [15:0]      w_clamped [NCH];
  logic [15:0]      w_tgt_nxt [NCH];
  logic [15:0]      w_next    [NCH];

  assign w_frame[FY1] = frame_fy1;
  assign w_frame[FW1] = frame_fw1;
  assign w_frame[FY2] = frame_fy2;
  assign w_frame[FW2] = frame_fw2;

  assign w_tick   = (r_cnt == CNT_LAST);
  assign w_accept = frame_valid & ~r_shadow_full;

  // The issued code is computed from the target as it will be after the move.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_tgt_nxt[g] = r_shadow_full ? r_shadow[g] : r_target[g];

    dac_slew_step #(
      .CODE_MIN (CODE_MIN),
      .CODE_MAX (CODE_MAX),
      .MAX_STEP (MAX_STEP)
    ) u_step (
      .i_raw     (w_frame[g]),
      .i_target  (w_tgt_nxt[g]),
      .i_last    (r_last[g]),
      .o_clamped (w_clamped[g]),
      .o_next    (w_next[g])
    );
  end

`ifdef DAC_SLEW_LIMIT_EN
  logic [NCH-1:0] w_ramping;
  for (genvar g = 0; g < NCH; g++) begin : g_ramp
    assign w_ramping[g] = (r_target[g] != r_last[g]);
  end
  assign w_work_pending = r_shadow_full | (|w_ramping);
`else
  assign w_work_pending = r_shadow_full;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && w_work_pending) begin
          w_state_nxt = ISSUE;
          w_issue     = 1'b1;
        end
      end
      ISSUE: begin
        if (dac_ready) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A same-edge accept wins over the issue clear: the new frame waits one tick.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shadow_full <= 1'b0;
      r_late        <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_issue)  r_shadow_full <= 1'b0;
      if (w_accept) r_shadow_full <= 1'b1;
      if (w_tick && (r_state == ISSUE) && (r_late != 8'hFF)) r_late <= r_late + 8'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_target[i] <= RESET_CODE;
        r_last[i]   <= RESET_CODE;
        r_dac[i]    <= RESET_CODE;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_issue) begin
          r_target[i] <= w_tgt_nxt[i];
          r_dac[i]    <= w_next[i];
        end
        if (w_done) r_last[i] <= r_dac[i];
      end
    end
  end

  // Shadow contents are only meaningful while r_shadow_full is set.
  always_ff @(posedge sysclk) begin
    if (w_accept) begin
      for (int i = 0; i < NCH; i++) r_shadow[i] <= w_clamped[i];
    end
  end

  assign frame_ready  = ~r_shadow_full;
  assign dac_valid    = (r_state == ISSUE);
  assign busy         = (r_state == ISSUE);
  assign late_cnt     = r_late;
  assign dac_data_fy1 = r_dac[FY1];
  assign dac_data_fw1 = r_dac[FW1];
  assign dac_data_fy2 = r_dac[FY2];
  assign dac_data_fw2 = r_dac[FW2];

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Self-checking bench for dac_frame_sequencer: vector table plus scoreboard of
// expected DAC transfers, with hand-written stall, tick-collision and reset cases.
module tb_dac_frame_sequencer;

  localparam int          UDIV  = 10;
  localparam logic [15:0] CMIN  = 16'h0010;
  localparam logic [15:0] CMAX  = 16'hF000;
  localparam logic [15:0] RCODE = 16'h8000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] frame_fy1 = '0, frame_fw1 = '0, frame_fy2 = '0, frame_fw2 = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [15:0] dac_data_fy1, dac_data_fw1, dac_data_fy2, dac_data_fw2;
  logic        dac_valid;
  logic        dac_ready = 1'b1;
  logic        busy;
  logic [7:0]  late_cnt;

  dac_frame_sequencer #(
    .UPDATE_DIV (UDIV),
    .CODE_MIN   (CMIN),
    .CODE_MAX   (CMAX),
    .RESET_CODE (RCODE),
    .MAX_STEP   (16'd256)
  ) dut (
    .sysclk       (clk),
    .rst          (rst),
    .frame_fy1    (frame_fy1),
    .frame_fw1    (frame_fw1),
    .frame_fy2    (frame_fy2),
    .frame_fw2    (frame_fw2),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .dac_data_fy1 (dac_data_fy1),
    .dac_data_fw1 (dac_data_fw1),
    .dac_data_fy2 (dac_data_fy2),
    .dac_data_fw2 (dac_data_fw2),
    .dac_valid    (dac_valid),
    .dac_ready    (dac_ready),
    .busy         (busy),
    .late_cnt     (late_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] din;
    logic [63:0] dexp;
  } vec_t;

  logic [63:0] w_dout;
  assign w_dout = {dac_data_fy1, dac_data_fw1, dac_data_fy2, dac_data_fw2};

  logic [63:0] sb_q[$];
  logic [63:0] m_last = {4{RCODE}};
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

`ifdef DAC_SLEW_LIMIT_EN
  function automatic logic [15:0] model_step(input logic [15:0] t, input logic [15:0] l);
    int d;
    d = int'(t) - int'(l);
    if (d > 256) d = 256;
    else if (d < -256) d = -256;
    return 16'(int'(l) + d);
  endfunction
`endif

  // Expected transfers for a (clamped) target, starting from the last issued codes.
  task automatic push_expected(input logic [63:0] t);
`ifdef DAC_SLEW_LIMIT_EN
    logic [63:0] nxt;
    for (int n = 0; n < 300 && m_last != t; n++) begin
      for (int c = 0; c < 4; c++) nxt[c*16 +: 16] = model_step(t[c*16 +: 16], m_last[c*16 +: 16]);
      sb_q.push_back(nxt);
      m_last = nxt;
    end
`else
    sb_q.push_back(t);
    m_last = t;
`endif
  endtask

  // Transfer monitor: one scoreboard entry per completed handshake.
  always @(negedge clk) begin
    if (rst && dac_valid && dac_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL xfer_unexpected: got %h, expected no transfer", w_dout);
      end else begin
        check("xfer_data", w_dout, sb_q.pop_front());
      end
    end
  end

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [63:0] f);
    int w;
    w = 0;
    while (!frame_ready && w < 4000) begin
      tick_wait(1);
      w++;
    end
    check("frame_ready_before_send", 64'(frame_ready), 64'd1);
    {frame_fy1, frame_fw1, frame_fy2, frame_fw2} = f;
    frame_valid = 1'b1;
    tick_wait(1);
    frame_valid = 1'b0;
    check("frame_ready_low_after_accept", 64'(frame_ready), 64'd0);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!dac_valid && lat < 4000) begin
      tick_wait(1);
      lat++;
    end
    if (!dac_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no dac_valid, expected dac_valid within bound", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || dac_valid) && w < 4000) begin
      tick_wait(1);
      w++;
    end
    check(name, 64'(sb_q.size()), 64'd0);
    tick_wait(3 * UDIV);
  endtask

  vec_t tbl [4];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bad;
    logic [63:0] held;

    tbl[0] = '{din: {16'd1000, 16'd2000, 16'd3000, 16'd4000}, dexp: {16'd1000, 16'd2000, 16'd3000, 16'd4000}};
    tbl[1] = '{din: {16'hFFFF, 16'h0000, 16'h0010, 16'hF000}, dexp: {16'hF000, 16'h0010, 16'h0010, 16'hF000}};
    tbl[2] = '{din: {16'hF001, 16'h000F, 16'h8000, 16'h1234}, dexp: {16'hF000, 16'h0010, 16'h8000, 16'h1234}};
    tbl[3] = '{din: {16'h8400, 16'h8000, 16'h7F00, 16'h8100}, dexp: {16'h8400, 16'h8000, 16'h7F00, 16'h8100}};

    // Reset state.
    tick_wait(3);
    check("rst_data", w_dout, {4{16'h8000}});
    check("rst_valid", 64'(dac_valid), 64'd0);
    check("rst_frame_ready", 64'(frame_ready), 64'd1);
    check("rst_late_cnt", 64'(late_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick_wait(2 * UDIV);
    check("idle_valid", 64'(dac_valid), 64'd0);
    check("idle_data", w_dout, {4{16'h8000}});

`ifdef DAC_SLEW_LIMIT_EN
    send_frame({16'h8400, 16'h8000, 16'h8000, 16'h8000});
    sb_q.push_back({16'h8100, 16'h8000, 16'h8000, 16'h8000});
    sb_q.push_back({16'h8200, 16'h8000, 16'h8000, 16'h8000});
    sb_q.push_back({16'h8300, 16'h8000, 16'h8000, 16'h8000});
    sb_q.push_back({16'h8400, 16'h8000, 16'h8000, 16'h8000});
    m_last = {16'h8400, 16'h8000, 16'h8000, 16'h8000};
    wait_drain("slew_ramp_drain");
`endif

    // Vector table with ready tied high.
    for (int v = 0; v < 4; v++) begin
      send_frame(tbl[v].din);
      push_expected(tbl[v].dexp);
      wait_valid("table_valid", lat);
      check("table_latency_in_range", 64'((lat + 1 >= 1) && (lat + 1 <= UDIV + 1)), 64'd1);
      tick_wait(1);
      check("table_valid_one_cycle", 64'(dac_valid), 64'd0);
      wait_drain("table_drain");
    end

    // Ready stall of 25 cycles: data held, two late ticks.
    dac_ready = 1'b0;
    send_frame({16'h1111, 16'h2222, 16'h3333, 16'h4444});
    push_expected({16'h1111, 16'h2222, 16'h3333, 16'h4444});
    wait_valid("stall_valid", lat);
    held = w_dout;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (!dac_valid || w_dout !== held) bad++;
      tick_wait(1);
    end
    check("stall_stable_cycles_bad", 64'(bad), 64'd0);
    check("stall_late_before_release", 64'(late_cnt), 64'd2);
    dac_ready = 1'b1;
    tick_wait(1);
    check("stall_valid_drops", 64'(dac_valid), 64'd0);
    check("stall_late_cnt", 64'(late_cnt), 64'd2);
    wait_drain("stall_drain");

    // Frame accepted on the tick edge is held until the following tick.
    send_frame({16'h1180, 16'h2280, 16'h3380, 16'h4480});
    push_expected({16'h1180, 16'h2280, 16'h3380, 16'h4480});
    wait_valid("collide_first_valid", lat);
    tick_wait(9);
    {frame_fy1, frame_fw1, frame_fy2, frame_fw2} = {16'h1200, 16'h2300, 16'h3400, 16'h4500};
    frame_valid = 1'b1;
    push_expected({16'h1200, 16'h2300, 16'h3400, 16'h4500});
    tick_wait(1);
    frame_valid = 1'b0;
    check("collide_ready_low", 64'(frame_ready), 64'd0);
    check("collide_no_issue", 64'(dac_valid), 64'd0);
    lat = 0;
    while (!dac_valid && lat < 30) begin
      tick_wait(1);
      lat++;
    end
    check("collide_issue_delay", 64'(lat), 64'd10);
    wait_drain("collide_drain");

    // Asynchronous reset during a stalled transfer with a frame in the shadow.
    dac_ready = 1'b0;
    send_frame({16'h5000, 16'h5000, 16'h5000, 16'h5000});
    wait_valid("rstmid_valid", lat);
    send_frame({16'h6000, 16'h6000, 16'h6000, 16'h6000});
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_valid", 64'(dac_valid), 64'd0);
    check("rstmid_data", w_dout, {4{16'h8000}});
    check("rstmid_frame_ready", 64'(frame_ready), 64'd1);
    check("rstmid_late_cnt", 64'(late_cnt), 64'd0);
    m_last = {4{RCODE}};
    tick_wait(2);
    rst = 1'b1;
    dac_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * UDIV; i++) begin
      if (dac_valid || w_dout !== {4{16'h8000}}) bad++;
      tick_wait(1);
    end
    check("rstmid_quiet_cycles_bad", 64'(bad), 64'd0);
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
